ct_ifu_vector_unit: RTL and testbench

Parametrised next-generation IFU trap-vector unit, sitting between RTU/CP0 and the PC generator. After reset it sequences the icache-invalidate request, then computes the redirect PC for every RTU exception or interrupt. Compared with the first-generation vector logic it adds a configurable vector-table stride and cause width, and a valid/ready handshake to pcgen with a one-entry pending buffer. It also adds an invalidate-request retry timer and dbgon abort rules.

---
 rtl/ct_ifu_vector_unit_pkg.sv | 42 ++++
 rtl/ct_ifu_vector_unit_if.sv | 40 ++++
 rtl/ct_ifu_vector_unit_retry_timer.sv | 39 +++
 rtl/ct_ifu_vector_unit.sv | 118 +++++++++++
 tb/tb_ct_ifu_vector_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_ifu_vector_unit_pkg.sv
// Shared types and PC arithmetic for the IFU trap-vector unit.
// State encodings, vector-mode constant and the redirect-PC helper.
package ct_ifu_vec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_RESET = 3'b010,
    ST_LOAD  = 3'b100
  } vec_state_e;

  localparam logic [1:0] VEC_MODE    = 2'b01;
  localparam int         MAX_PC_W    = 64;
  localparam int         MAX_CAUSE_W = 16;

  // Result is in halfword units; the caller truncates to PC_WIDTH-1 bits,
  // which gives the modulo wrap of the vectored offset for free.
  function automatic logic [MAX_PC_W-1:0] vec_pc(
    input logic [MAX_PC_W-1:0]    vbr,
    input logic [MAX_CAUSE_W-1:0] cause,
    input logic [MAX_PC_W-1:0]    rvbr,
    input int                     cause_w,
    input int                     entry_shift
  );
    logic [MAX_CAUSE_W-1:0] flag_mask;
    logic [MAX_CAUSE_W-1:0] code_mask;
    logic [MAX_CAUSE_W-1:0] code;
    logic                   intr;
    logic [MAX_PC_W-1:0]    direct;
    flag_mask = MAX_CAUSE_W'(1) << (cause_w - 1);
    code_mask = flag_mask - MAX_CAUSE_W'(1);
    code      = cause & code_mask;
    intr      = |(cause & flag_mask);
    direct    = (vbr >> 1) & ~MAX_PC_W'(1);
    if (!intr && code == '0)
      vec_pc = rvbr >> 1;
    else if (intr && vbr[1:0] == VEC_MODE)
      vec_pc = direct + (MAX_PC_W'(code) << (entry_shift - 1));
    else
      vec_pc = direct;
  endfunction

endpackage

// File: rtl/ct_ifu_vector_unit_if.sv
// CP0/RTU/pcgen signal bundle of the trap-vector unit.
// The slave modport is the vector unit's view; master is its environment.
interface ct_ifu_vector_unit_if #(
  parameter int PC_WIDTH = 40,
  parameter int CAUSE_W  = 6
);
  logic [PC_WIDTH-1:0] cp0_ifu_rvbr;
  logic [PC_WIDTH-1:0] cp0_ifu_vbr;
  logic                cp0_ifu_rst_inv_done;
  logic                rtu_ifu_xx_expt_vld;
  logic [CAUSE_W-1:0]  rtu_ifu_xx_expt_vec;
  logic                rtu_ifu_xx_dbgon;
  logic                pcgen_vector_ready;
  logic                ifu_cp0_rst_inv_req;
  logic                ifu_xx_sync_reset;
  logic                vector_pcgen_pcload;
  logic [PC_WIDTH-2:0] vector_pcgen_pc;
  logic                vector_pcgen_reset_on;
  logic                vector_ifctrl_sm_on;
  logic                vector_ifctrl_sm_start;
  logic [2:0]          vector_debug_cur_st;

  modport slave (
    input  cp0_ifu_rvbr, cp0_ifu_vbr, cp0_ifu_rst_inv_done,
           rtu_ifu_xx_expt_vld, rtu_ifu_xx_expt_vec, rtu_ifu_xx_dbgon,
           pcgen_vector_ready,
    output ifu_cp0_rst_inv_req, ifu_xx_sync_reset, vector_pcgen_pcload,
           vector_pcgen_pc, vector_pcgen_reset_on, vector_ifctrl_sm_on,
           vector_ifctrl_sm_start, vector_debug_cur_st
  );

  modport master (
    output cp0_ifu_rvbr, cp0_ifu_vbr, cp0_ifu_rst_inv_done,
           rtu_ifu_xx_expt_vld, rtu_ifu_xx_expt_vec, rtu_ifu_xx_dbgon,
           pcgen_vector_ready,
    input  ifu_cp0_rst_inv_req, ifu_xx_sync_reset, vector_pcgen_pcload,
           vector_pcgen_pc, vector_pcgen_reset_on, vector_ifctrl_sm_on,
           vector_ifctrl_sm_start, vector_debug_cur_st
  );
endinterface

// File: rtl/ct_ifu_vector_unit_retry_timer.sv
// Invalidate-request retry timer: restarts on start, stops on clear and
// pulses expire INV_TMO cycles after the last start.
module ct_ifu_vec_retry_timer #(
  parameter int INV_TMO = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  if (INV_TMO == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = ^{clk, rst, start, clear};
    assign expire     = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(INV_TMO + 1);
    logic [CW-1:0] cnt;
    logic          running;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        cnt     <= '0;
        running <= 1'b0;
      end else if (start) begin
        cnt     <= '0;
        running <= 1'b1;
      end else if (running) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign expire = running && (cnt == CW'(INV_TMO - 1));
  end

endmodule

// File: rtl/ct_ifu_vector_unit.sv
// IFU trap-vector unit: sequences the post-reset icache invalidate, then
// computes redirect PCs for RTU traps with a one-entry pending buffer.
module ct_ifu_vector_unit
  import ct_ifu_vec_pkg::*;
#(
  parameter int PC_WIDTH    = 40,
  parameter int CAUSE_W     = 6,
  parameter int ENTRY_SHIFT = 2,
  parameter int INV_TMO     = 64
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  ct_ifu_vector_unit_if.slave   vif
);

  localparam int PCW = PC_WIDTH - 1;

  vec_state_e     state, state_nxt;
  logic [PCW-1:0] pc, pc_nxt;
  logic [PCW-1:0] pend_pc, pend_pc_nxt;
  logic           pend_vld, pend_vld_nxt;
  logic           first;
  logic           inv_req;
  logic           tmo_expire;
  logic [PCW-1:0] expt_pc;
  logic [PCW-1:0] rst_pc;

  assign expt_pc = PCW'(vec_pc(MAX_PC_W'(vif.cp0_ifu_vbr),
                               MAX_CAUSE_W'(vif.rtu_ifu_xx_expt_vec),
                               MAX_PC_W'(vif.cp0_ifu_rvbr),
                               CAUSE_W, ENTRY_SHIFT));
  assign rst_pc  = vif.cp0_ifu_rvbr[PC_WIDTH-1:1];

  ct_ifu_vec_retry_timer #(.INV_TMO(INV_TMO)) u_retry_timer (
    .clk    (forever_cpuclk),
    .rst    (cpurst),
    .start  (inv_req),
    .clear  (state != ST_RESET),
    .expire (tmo_expire)
  );

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state    <= ST_RESET;
      pc       <= '0;
      pend_pc  <= '0;
      pend_vld <= 1'b0;
      first    <= 1'b1;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_pc  <= pend_pc_nxt;
      pend_vld <= pend_vld_nxt;
      first    <= 1'b0;
    end
  end

  // NOTE: every next-state variable gets a hold default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_pc_nxt  = pend_pc;
    pend_vld_nxt = pend_vld;
    case (state)
      ST_RESET: begin
        if (vif.cp0_ifu_rst_inv_done) begin
          pc_nxt    = rst_pc;
          state_nxt = ST_LOAD;
        end
      end
      ST_IDLE: begin
        if (vif.rtu_ifu_xx_dbgon) begin
          pend_vld_nxt = 1'b0;
        end else if (vif.rtu_ifu_xx_expt_vld) begin
          pc_nxt    = expt_pc;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (vif.rtu_ifu_xx_dbgon) begin
          state_nxt    = ST_IDLE;
          pend_vld_nxt = 1'b0;
        end else if (vif.pcgen_vector_ready) begin
          // A trap on the handshake cycle supersedes anything still pending.
          if (vif.rtu_ifu_xx_expt_vld) begin
            pc_nxt       = expt_pc;
            pend_vld_nxt = 1'b0;
          end else if (pend_vld) begin
            pc_nxt       = pend_pc;
            pend_vld_nxt = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (vif.rtu_ifu_xx_expt_vld) begin
          pend_pc_nxt  = expt_pc;
          pend_vld_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  always_comb begin
    inv_req = (state == ST_RESET) && !cpurst &&
              (first || (tmo_expire && !vif.cp0_ifu_rst_inv_done));
    vif.ifu_cp0_rst_inv_req    = inv_req;
    vif.ifu_xx_sync_reset      = (state == ST_RESET);
    vif.vector_pcgen_reset_on  = (state == ST_RESET);
    vif.vector_ifctrl_sm_on    = (state != ST_IDLE);
    vif.vector_ifctrl_sm_start = ((state != ST_IDLE) && (state != ST_RESET)) ||
                                 vif.rtu_ifu_xx_expt_vld;
    vif.vector_pcgen_pcload    = (state == ST_LOAD) && !vif.rtu_ifu_xx_dbgon;
    vif.vector_pcgen_pc        = pc;
    vif.vector_debug_cur_st    = state;
  end

endmodule

// File: tb/tb_ct_ifu_vector_unit.sv
// Self-checking bench for ct_ifu_vector_unit: vector table plus hand-written
// reset, pending-buffer, dbgon and retry sequences, with a PC scoreboard.
module tb_ct_ifu_vector_unit;
  localparam int PC_WIDTH    = 40;
  localparam int CAUSE_W     = 6;
  localparam int ENTRY_SHIFT = 2;
  localparam int INV_TMO     = 8;
  localparam logic [2:0] S_IDLE = 3'b001, S_RESET = 3'b010, S_LOAD = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ct_ifu_vector_unit_if #(.PC_WIDTH(PC_WIDTH), .CAUSE_W(CAUSE_W)) vif ();

  ct_ifu_vector_unit #(
    .PC_WIDTH(PC_WIDTH), .CAUSE_W(CAUSE_W),
    .ENTRY_SHIFT(ENTRY_SHIFT), .INV_TMO(INV_TMO)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .vif            (vif)
  );

  typedef struct {
    logic [39:0] vbr;
    logic [5:0]  cause;
    logic [39:0] rvbr;
    logic [38:0] exp_pc;
  } vec_t;

  vec_t        tbl[10];
  logic [38:0] sb_q[$];
  int          n_run  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [38:0] model_pc(input logic [39:0] vbr, input logic [5:0] cause,
                                           input logic [39:0] rvbr);
    logic [38:0] base;
    int unsigned code;
    code = cause[4:0];
    base = {vbr[39:2], 1'b0};
    if (!cause[5] && code == 0) return rvbr[39:1];
    if (cause[5] && vbr[1:0] == 2'b01) return base + 39'(code * (1 << (ENTRY_SHIFT - 1)));
    return base;
  endfunction

  task automatic raise(input logic [39:0] vbr, input logic [5:0] cause);
    vif.cp0_ifu_vbr         = vbr;
    vif.rtu_ifu_xx_expt_vec = cause;
    vif.rtu_ifu_xx_expt_vld = 1'b1;
  endtask

  task automatic expect_pop(input string name);
    logic [38:0] e;
    if (sb_q.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: pc %0h loaded, expected no entry", name, vif.vector_pcgen_pc);
    end else begin
      e = sb_q.pop_front();
      check({name, "_pcload"}, vif.vector_pcgen_pcload, 1);
      check(name, vif.vector_pcgen_pc, e);
    end
  endtask

  initial begin
    int n_req;
    logic [39:0] va, vb, vc;

    vif.cp0_ifu_rvbr         = 40'h00_1234_5678;
    vif.cp0_ifu_vbr          = 40'h00_0008_0001;
    vif.cp0_ifu_rst_inv_done = 1'b0;
    vif.rtu_ifu_xx_expt_vld  = 1'b0;
    vif.rtu_ifu_xx_expt_vec  = '0;
    vif.rtu_ifu_xx_dbgon     = 1'b0;
    vif.pcgen_vector_ready   = 1'b0;

    tbl[0] = '{40'h00_0008_0001, 6'h27, 40'h0, 39'h4_000E};          // vectored, code 7
    tbl[1] = '{40'h00_0008_0001, 6'h07, 40'h0, 39'h4_0000};          // exception: direct
    tbl[2] = '{40'h00_0008_0000, 6'h27, 40'h0, 39'h4_0000};          // mode 00: direct
    tbl[3] = '{40'h00_0008_0003, 6'h3F, 40'h0, 39'h4_0000};          // mode 11: direct
    tbl[4] = '{40'h00_0008_0001, 6'h00, 40'hAB_CD00_0000, 39'h55_E680_0000}; // reset exception
    tbl[5] = '{40'h00_0008_0001, 6'h20, 40'h0, 39'h4_0000};          // interrupt code 0
    tbl[6] = '{40'hFF_FFFF_FFFD, 6'h3F, 40'h0, 39'h3C};              // modulo wrap
    for (int i = 7; i < 10; i++) begin
      tbl[i].vbr   = {8'($urandom_range(255)), 30'($urandom), 2'b01};
      tbl[i].cause = 6'($urandom_range(63));
      tbl[i].rvbr  = {8'($urandom_range(255)), 32'($urandom)};
      tbl[i].exp_pc = model_pc(tbl[i].vbr, tbl[i].cause, tbl[i].rvbr);
    end

    // Reset state while cpurst is held.
    repeat (3) cyc();
    #1;
    check("rst_sync_reset", vif.ifu_xx_sync_reset, 1);
    check("rst_reset_on", vif.vector_pcgen_reset_on, 1);
    check("rst_cur_st", vif.vector_debug_cur_st, S_RESET);
    check("rst_pcload", vif.vector_pcgen_pcload, 0);
    check("rst_req_held", vif.ifu_cp0_rst_inv_req, 0);
    check("rst_pc", vif.vector_pcgen_pc, 0);

    // Release; done arrives five cycles after the request.
    rst = 1'b0;
    n_req = 0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) cyc();
      if (c == 5) vif.cp0_ifu_rst_inv_done = 1'b1;
      #1;
      n_req += int'(vif.ifu_cp0_rst_inv_req);
      if (c == 0) check("req_first", vif.ifu_cp0_rst_inv_req, 1);
    end
    check("req_count", n_req, 1);
    check("rst_sm_start", vif.vector_ifctrl_sm_start, 0);
    sb_q.push_back(39'h09_1A2B_3C);
    cyc(); #1;
    check("done_cur_st", vif.vector_debug_cur_st, S_LOAD);
    check("done_sync_reset", vif.ifu_xx_sync_reset, 0);
    vif.pcgen_vector_ready = 1'b1;
    #1;
    expect_pop("reset_pc");
    cyc();
    vif.pcgen_vector_ready = 1'b0;
    #1;
    check("after_rst_idle", vif.vector_debug_cur_st, S_IDLE);
    check("after_rst_pcload", vif.vector_pcgen_pcload, 0);
    check("after_rst_sm_on", vif.vector_ifctrl_sm_on, 0);

    // Table-driven vectors, each one trap through IDLE -> LOAD -> IDLE.
    for (int i = 0; i < 10; i++) begin
      vif.cp0_ifu_rvbr = tbl[i].rvbr;
      raise(tbl[i].vbr, tbl[i].cause);
      sb_q.push_back(tbl[i].exp_pc);
      #1;
      check("tbl_sm_start", vif.vector_ifctrl_sm_start, 1);
      cyc();
      vif.rtu_ifu_xx_expt_vld = 1'b0;
      #1;
      check("tbl_cur_st", vif.vector_debug_cur_st, S_LOAD);
      vif.pcgen_vector_ready = 1'b1;
      #1;
      expect_pop($sformatf("tbl%0d_pc", i));
      cyc();
      vif.pcgen_vector_ready = 1'b0;
      #1;
      check("tbl_back_idle", vif.vector_debug_cur_st, S_IDLE);
    end

    vif.cp0_ifu_rvbr = 40'h00_0000_4000;
    va = 40'h00_0010_0001;
    vb = 40'h00_0020_0001;
    vc = 40'h00_0030_0001;

    // A then B with ready low: pc = A, B pending, two handshakes.
    raise(va, 6'h21); sb_q.push_back(model_pc(va, 6'h21, vif.cp0_ifu_rvbr));
    cyc();
    raise(vb, 6'h22); sb_q.push_back(model_pc(vb, 6'h22, vif.cp0_ifu_rvbr));
    cyc();
    vif.rtu_ifu_xx_expt_vld = 1'b0;
    vif.pcgen_vector_ready  = 1'b1;
    #1;
    expect_pop("pend_first");
    cyc(); #1;
    check("pend_still_load", vif.vector_debug_cur_st, S_LOAD);
    expect_pop("pend_second");
    cyc();
    vif.pcgen_vector_ready = 1'b0;
    #1;
    check("pend_done_idle", vif.vector_debug_cur_st, S_IDLE);
    check("pend_sb_empty", sb_q.size(), 0);

    // A, B, C: C overwrites pending B.
    raise(va, 6'h23); sb_q.push_back(model_pc(va, 6'h23, vif.cp0_ifu_rvbr));
    cyc();
    raise(vb, 6'h24); sb_q.push_back(model_pc(vb, 6'h24, vif.cp0_ifu_rvbr));
    cyc();
    raise(vc, 6'h25); sb_q[sb_q.size() - 1] = model_pc(vc, 6'h25, vif.cp0_ifu_rvbr);
    cyc();
    vif.rtu_ifu_xx_expt_vld = 1'b0;
    vif.pcgen_vector_ready  = 1'b1;
    #1;
    expect_pop("ovw_first");
    cyc(); #1;
    expect_pop("ovw_newest");
    cyc();
    vif.pcgen_vector_ready = 1'b0;
    #1;
    check("ovw_idle", vif.vector_debug_cur_st, S_IDLE);

    // Trap on the handshake cycle: goes straight to pc, pending B dropped.
    raise(va, 6'h26); sb_q.push_back(model_pc(va, 6'h26, vif.cp0_ifu_rvbr));
    cyc();
    raise(vb, 6'h27); sb_q.push_back(model_pc(vb, 6'h27, vif.cp0_ifu_rvbr));
    cyc();
    raise(vc, 6'h28);
    vif.pcgen_vector_ready = 1'b1;
    #1;
    expect_pop("hs_first");
    void'(sb_q.pop_front());
    sb_q.push_back(model_pc(vc, 6'h28, vif.cp0_ifu_rvbr));
    cyc();
    vif.rtu_ifu_xx_expt_vld = 1'b0;
    #1;
    check("hs_stay_load", vif.vector_debug_cur_st, S_LOAD);
    expect_pop("hs_new_pc");
    cyc();
    vif.pcgen_vector_ready = 1'b0;
    #1;
    check("hs_idle", vif.vector_debug_cur_st, S_IDLE);

    // dbgon in LOAD with pending set.
    raise(va, 6'h29); sb_q.push_back(model_pc(va, 6'h29, vif.cp0_ifu_rvbr));
    cyc();
    raise(vb, 6'h2A); sb_q.push_back(model_pc(vb, 6'h2A, vif.cp0_ifu_rvbr));
    cyc();
    vif.rtu_ifu_xx_expt_vld = 1'b0;
    vif.rtu_ifu_xx_dbgon    = 1'b1;
    #1;
    check("dbg_pcload", vif.vector_pcgen_pcload, 0);
    sb_q.delete();
    cyc(); #1;
    check("dbg_idle", vif.vector_debug_cur_st, S_IDLE);
    vif.rtu_ifu_xx_dbgon   = 1'b0;
    vif.pcgen_vector_ready = 1'b1;
    cyc(); #1;
    check("dbg_stay_idle", vif.vector_debug_cur_st, S_IDLE);
    check("dbg_no_pcload", vif.vector_pcgen_pcload, 0);
    vif.pcgen_vector_ready = 1'b0;
    raise(vc, 6'h2B); sb_q.push_back(model_pc(vc, 6'h2B, vif.cp0_ifu_rvbr));
    cyc();
    vif.rtu_ifu_xx_expt_vld = 1'b0;
    vif.pcgen_vector_ready  = 1'b1;
    #1;
    expect_pop("dbg_after_pc");
    cyc();
    vif.pcgen_vector_ready = 1'b0;
    #1;
    check("dbg_pend_cleared", vif.vector_debug_cur_st, S_IDLE);

    // cpurst mid-operation with pending set, then retry timer with dbgon/expt ignored.
    raise(va, 6'h2C);
    cyc();
    raise(vb, 6'h2D);
    cyc();
    vif.rtu_ifu_xx_expt_vld  = 1'b0;
    vif.cp0_ifu_rst_inv_done = 1'b0;
    rst = 1'b1;
    cyc(); #1;
    check("midrst_cur_st", vif.vector_debug_cur_st, S_RESET);
    sb_q.delete();
    rst = 1'b0;
    vif.rtu_ifu_xx_dbgon = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) cyc();
      vif.rtu_ifu_xx_expt_vld = (c == 3 || c == 11);
      if (c == 20) begin
        vif.rtu_ifu_xx_dbgon     = 1'b0;
        vif.cp0_ifu_rst_inv_done = 1'b1;
      end
      #1;
      check($sformatf("retry_req_c%0d", c), vif.ifu_cp0_rst_inv_req, (c % 8 == 0));
      if (c % 4 == 3) begin
        check("retry_sync_reset", vif.ifu_xx_sync_reset, 1);
        check("retry_cur_st", vif.vector_debug_cur_st, S_RESET);
      end
    end
    sb_q.push_back(39'h00_0000_2000);
    cyc();
    vif.rtu_ifu_xx_expt_vld = 1'b0;
    vif.pcgen_vector_ready  = 1'b1;
    #1;
    check("retry_load", vif.vector_debug_cur_st, S_LOAD);
    expect_pop("retry_reset_pc");
    cyc();
    vif.pcgen_vector_ready = 1'b0;
    #1;
    check("midrst_pend_dropped", vif.vector_debug_cur_st, S_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
